seg7_scan_driver: RTL
=====================

SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 SHALL have parameter DIGITS, default 8: number of hex digits/anodes, legal range 2..8.
REQ-002 SHALL have parameter DWELL, default 4: clk_out cycles each digit is lit, legal range >=1.
REQ-003 SHALL have parameter DEAD, default 1: all-off clk_out cycles after each digit (anti-ghosting), legal range >=1.
REQ-004 SHALL have port clk_out  in  1  scan clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port load  in  1  single-cycle request to capture data_in/dp_in.
REQ-007 SHALL have port data_in  in  4*DIGITS  hex nibbles; digit k = data_in[4k+3:4k].
REQ-008 SHALL have port dp_in  in  DIGITS  decimal point per digit, 1 = lit.
REQ-009 SHALL have port an  out  DIGITS  anode enables, active-low, an[k] drives digit k.
REQ-010 SHALL have port seg  out  7  segments, active-low, seg[0]=a ... seg[6]=g.
REQ-011 SHALL have port dp  out  1  decimal point, active-low.
REQ-012 SHALL have port frame_done  out  1  one-cycle pulse at end of every frame.

Function
REQ-013 SHALL hold a pending register (data, dp, pending_valid) and a display register (data, dp); all outputs SHALL be registered.
REQ-014 On load=1, pending SHALL capture data_in/dp_in and set pending_valid; a later load before the frame boundary SHALL overwrite it (last wins).
REQ-015 FSM SHALL have states SHOW and BLANK plus a digit index idx (0..DIGITS-1) and a cycle counter.
REQ-016 SHOW SHALL last exactly DWELL cycles with an[idx]=0 and all other an bits 1, then go to BLANK.
REQ-017 BLANK SHALL last exactly DEAD cycles with an all 1, seg=7'h7F, dp=1; then idx increments and SHOW resumes.
REQ-018 Frame boundary = final BLANK cycle with idx=DIGITS-1; there idx SHALL wrap to 0, frame_done SHALL be 1 for that one cycle, and if pending_valid the display register SHALL take pending and pending_valid SHALL clear.
REQ-019 If load=1 in the boundary cycle, data_in/dp_in SHALL go directly to the display register and pending_valid SHALL end at 0 (load wins).
REQ-020 Display register SHALL never change except at a boundary (tear-free frames).
REQ-021 Frame length SHALL be DIGITS*(DWELL+DEAD) cycles; digit k lit from cycle k*(DWELL+DEAD) of the frame.
REQ-022 seg SHALL be the active-low hex decode of the lit nibble: 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10, A=7'h08, b=7'h03, C=7'h46, d=7'h21, E=7'h06, F=7'h0E.
REQ-023 During SHOW, dp SHALL be ~dp bit of the lit digit.

Reset
REQ-024 reset=0 SHALL immediately force an all 1, seg=7'h7F, dp=1, frame_done=0, display/pending data and dp 0, pending_valid 0, regardless of clock and including mid-frame.
REQ-025 Reset state SHALL be BLANK, idx=DIGITS-1, counter at its final value, so the first clock after release is a frame boundary (frame_done=1) and digit 0 lights on the following cycle.

Configuration
REQ-026 With macro LEADING_ZERO_BLANK_EN defined, digit k (k>=1) SHALL show seg=7'h7F when it and all higher digits are 0; anode timing and dp unchanged; digit 0 never blanked.
REQ-027 Without LEADING_ZERO_BLANK_EN, every digit SHALL be decoded per REQ-022, zeros included.

Verification (DIGITS=8, DWELL=4, DEAD=1)
REQ-028 Release reset, no load -> frame_done at cycle 1, then every 40 cycles; each digit shows seg=7'h40 for 4 cycles, then 1 cycle an=8'hFF.
REQ-029 Load data_in=32'h89ABCDEF, dp_in=8'h01 mid-frame -> current frame unchanged; next frame digit 0 seg=7'h0E dp=0, digit 7 seg=7'h00 dp=1.
REQ-030 Two loads in one frame (32'h11111111 then 32'h22222222) -> next frame shows only 2s (seg=7'h24).
REQ-031 Load 32'h00000005 in the boundary cycle -> frame starting next cycle shows digit 0 seg=7'h12; next boundary leaves display unchanged.
REQ-032 With LEADING_ZERO_BLANK_EN, data 32'h00000305 -> digits 3..7 seg=7'h7F, digit 2 7'h30, digit 1 7'h40, digit 0 7'h12; without it digits 3..7 7'h40.
REQ-033 Assert reset during digit 4 SHOW -> same cycle an=8'hFF, seg=7'h7F, dp=1; after release, REQ-025 sequence with zeros displayed.

Source files
------------

// File: rtl/seg7_scan_driver_if.sv
// Bus bundle for the multiplexed 7-segment scan driver: load request with
// nibble/dp data in, anode/segment/dp drive and frame pulse out.
interface seg7_scan_driver_if #(parameter int DIGITS = 8);
  logic                  load;
  logic [4*DIGITS-1:0]   data_in;
  logic [DIGITS-1:0]     dp_in;
  logic [DIGITS-1:0]     an;
  logic [6:0]            seg;
  logic                  dp;
  logic                  frame_done;

  modport master (output load, data_in, dp_in, input an, seg, dp, frame_done);
  modport slave  (input load, data_in, dp_in, output an, seg, dp, frame_done);
endinterface

// File: rtl/seg7_scan_driver.sv
// Multiplexed hex display scanner with double-buffered, tear-free frame updates.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 never).
//
// state | meaning
// SHOW  | digit idx lit for DWELL cycles
// BLANK | all anodes off for DEAD cycles; final BLANK of idx=DIGITS-1 ends the frame
module seg7_scan_driver #(
  parameter int DIGITS = 8,
  parameter int DWELL  = 4,
  parameter int DEAD   = 1
) (
  input  logic               clk_out,
  input  logic               reset,
  seg7_scan_driver_if.slave  bus
);
  localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CMAX = (DWELL > DEAD) ? DWELL : DEAD;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  typedef enum logic {SHOW, BLANK} state_t;

  state_t              state, state_nx;
  logic [IW-1:0]       idx, idx_nx;
  logic [CW-1:0]       cnt, cnt_nx;
  logic                frame_end;

  logic [4*DIGITS-1:0] disp_data, disp_data_nx, pend_data;
  logic [DIGITS-1:0]   disp_dp, disp_dp_nx, pend_dp;
  logic                pend_valid;

  logic [DIGITS-1:0]   an_q;
  logic [6:0]          seg_q;
  logic                dp_q;
  logic                fd_q;

  logic [3:0]          nib;
  logic                lz_blank;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
    endcase
  endfunction

  always_ff @(posedge clk_out or negedge reset) begin
    if (!reset) begin
      state <= BLANK;
      idx   <= IW'(DIGITS - 1);
      cnt   <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    idx_nx    = idx;
    cnt_nx    = cnt - 1'b1;
    frame_end = 1'b0;
    case (state)
      SHOW: begin
        if (cnt == '0) begin
          state_nx = BLANK;
          cnt_nx   = CW'(DEAD - 1);
        end
      end
      default: begin
        if (cnt == '0) begin
          state_nx  = SHOW;
          cnt_nx    = CW'(DWELL - 1);
          frame_end = (idx == IW'(DIGITS - 1));
          idx_nx    = frame_end ? '0 : idx + 1'b1;
        end
      end
    endcase
  end

  // fd_q marks the visible boundary cycle; the display swaps at its closing edge,
  // so a load in that same cycle goes straight to the display.
  always_comb begin
    disp_data_nx = disp_data;
    disp_dp_nx   = disp_dp;
    if (fd_q) begin
      if (bus.load) begin
        disp_data_nx = bus.data_in;
        disp_dp_nx   = bus.dp_in;
      end else if (pend_valid) begin
        disp_data_nx = pend_data;
        disp_dp_nx   = pend_dp;
      end
    end
  end

  always_ff @(posedge clk_out or negedge reset) begin
    if (!reset) begin
      disp_data  <= '0;
      disp_dp    <= '0;
      pend_data  <= '0;
      pend_dp    <= '0;
      pend_valid <= 1'b0;
    end else begin
      disp_data <= disp_data_nx;
      disp_dp   <= disp_dp_nx;
      if (fd_q) begin
        pend_valid <= 1'b0;
      end else if (bus.load) begin
        pend_data  <= bus.data_in;
        pend_dp    <= bus.dp_in;
        pend_valid <= 1'b1;
      end
    end
  end

  assign nib = disp_data_nx[{idx, 2'b00} +: 4];

`ifdef LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] zero_above;
  always_comb begin
    logic run;
    zero_above = '0;
    run        = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      run           = run & (disp_data_nx[4*k +: 4] == 4'h0);
      zero_above[k] = run;
    end
  end
  assign lz_blank = (idx != '0) && zero_above[idx];
`else
  assign lz_blank = 1'b0;
`endif

  always_ff @(posedge clk_out or negedge reset) begin
    if (!reset) begin
      an_q  <= '1;
      seg_q <= 7'h7F;
      dp_q  <= 1'b1;
      fd_q  <= 1'b0;
    end else begin
      fd_q <= frame_end;
      if (state == SHOW) begin
        an_q  <= ~(DIGITS'(1) << idx);
        seg_q <= lz_blank ? 7'h7F : hex7(nib);
        dp_q  <= ~disp_dp_nx[idx];
      end else begin
        an_q  <= '1;
        seg_q <= 7'h7F;
        dp_q  <= 1'b1;
      end
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.frame_done = fd_q;
endmodule
